// File: rtl/batch_sequencer.sv
// Batch-cycle control for the control-bounded filter datapath: sample counters,
// 4-phase buffer rotation, RAM write strobes and output qualification on one clock.
module batch_sequencer #(
    parameter int depth = 32,
    parameter int OSR   = 2,
    localparam int DS   = depth / OSR,
    localparam int AW   = $clog2(depth),
    localparam int DW   = (DS > 1) ? $clog2(DS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          flush,
    output logic [AW-1:0] bat_cnt,
    output logic [AW-1:0] bat_cnt_rev,
    output logic [DW-1:0] down_cnt,
    output logic [DW-1:0] down_cnt_rev,
    output logic          ds_en,
    output logic [1:0]    cycle,
    output logic [3:0]    sample_we,
    output logic          calc_bank,
    output logic          lh_rst_n,
    output logic          batch_end,
    output logic          out_valid,
    output logic          busy
);

    if (depth < 4 || (depth & (depth - 1)) != 0) begin : g_bad_depth
        $error("batch_sequencer: depth must be a power of two >= 4");
    end
    if (OSR < 1 || (depth % OSR) != 0) begin : g_bad_osr
        $error("batch_sequencer: OSR must divide depth");
    end

    localparam int OW = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic [AW-1:0] BAT_MAX  = AW'(depth - 1);
    localparam logic [DW-1:0] DOWN_MAX = DW'(DS - 1);
    localparam logic [OW-1:0] OSR_MAX  = OW'(OSR - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    fill_cnt;
    logic [OW-1:0] osr_cnt;
    logic          accepted;
    logic          osr_last;

    // A flushed sample is dropped outright, so every strobe derives from accepted.
    assign accepted  = in_valid && !flush;
    assign osr_last  = (osr_cnt == OSR_MAX);
    assign ds_en     = accepted && osr_last;
    assign batch_end = accepted && (bat_cnt == BAT_MAX);
    assign sample_we = ds_en ? (4'b0001 << cycle) : 4'b0000;
    assign calc_bank = cycle[0];
    assign lh_rst_n  = !batch_end;
    assign out_valid = ds_en && (state == RUN);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            osr_cnt      <= '0;
            bat_cnt      <= '0;
            bat_cnt_rev  <= BAT_MAX;
            down_cnt     <= '0;
            down_cnt_rev <= DOWN_MAX;
            cycle        <= 2'd0;
        end else if (flush) begin
            osr_cnt      <= '0;
            bat_cnt      <= '0;
            bat_cnt_rev  <= BAT_MAX;
            down_cnt     <= '0;
            down_cnt_rev <= DOWN_MAX;
            cycle        <= 2'd0;
        end else if (accepted) begin
            osr_cnt     <= osr_last ? '0 : osr_cnt + 1'b1;
            bat_cnt     <= bat_cnt + 1'b1;
            bat_cnt_rev <= bat_cnt_rev - 1'b1;
            if (ds_en) begin
                // DS may be 1, so wrap explicitly rather than relying on overflow.
                down_cnt     <= (down_cnt == DOWN_MAX) ? '0 : down_cnt + 1'b1;
                down_cnt_rev <= (down_cnt_rev == '0) ? DOWN_MAX : down_cnt_rev - 1'b1;
            end
            if (batch_end) begin
                cycle <= cycle + 2'd1;
            end
        end
    end

    // Three completed batches fill the lookahead buffers before results are valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fill_cnt <= 2'd0;
        end else if (flush) begin
            state    <= IDLE;
            fill_cnt <= 2'd0;
        end else if (accepted) begin
            case (state)
                IDLE: state <= FILL;
                FILL: begin
                    if (batch_end) begin
                        if (fill_cnt == 2'd2) begin
                            state    <= RUN;
                            fill_cnt <= 2'd0;
                        end else begin
                            fill_cnt <= fill_cnt + 2'd1;
                        end
                    end
                end
                RUN:     state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
